// File: rtl/dma_irq_ctrl_if.sv
// CSR bus between the host-side Avalon-MM master and dma_irq_ctrl.
// Fixed 1-cycle read latency; waitrequest is never asserted by the slave.
interface dma_irq_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [63:0] avs_writedata;
  logic [7:0]  avs_byteenable;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/dma_irq_ctrl.sv
// DMA completion interrupt controller: sticky W1C status, enables, level irq with ack handshake.
// Define DMA_IRQ_CTRL_COUNTERS_EN to build the per-direction completion counters (words 2-3).
module dma_irq_ctrl #(
  parameter logic [63:0] ID_VALUE  = 64'h0000_0000_D1A1_0001,
  parameter int          CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dma_irq_host2fpga,
  input  logic         dma_irq_fpga2host,
  input  logic         f2h_dma_wr_fence_flag,
  dma_irq_ctrl_if.slave avs,
  output logic         irq_req,
  input  logic         irq_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_CLR = 2'd2} irq_state_e;

  logic [1:0]  status_q, status_d;
  logic [1:0]  enable_q, enable_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rvld_q, rvld_d;
  irq_state_e  state_q, state_d;

  logic        wr_lane0;
  logic [1:0]  set_vec, clr_vec;
  logic        pending;
  logic [63:0] cnt_h2f_rd, cnt_f2h_rd;

  assign wr_lane0 = avs.avs_write & avs.avs_byteenable[0];
  assign set_vec  = {dma_irq_fpga2host, dma_irq_host2fpga};
  assign clr_vec  = (wr_lane0 && avs.avs_address == 3'd0) ? avs.avs_writedata[1:0] : 2'b00;

  // Set is OR'd after the clear so a coincident completion survives a W1C.
  always_comb begin
    status_d = (status_q & ~clr_vec) | set_vec;
    enable_d = enable_q;
    if (wr_lane0 && avs.avs_address == 3'd1) enable_d = avs.avs_writedata[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      enable_q <= '0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
    end
  end

`ifdef DMA_IRQ_CTRL_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_h2f_q, cnt_h2f_d;
  logic [CNT_WIDTH-1:0] cnt_f2h_q, cnt_f2h_d;

  always_comb begin
    cnt_h2f_d = cnt_h2f_q + CNT_WIDTH'(dma_irq_host2fpga);
    cnt_f2h_d = cnt_f2h_q + CNT_WIDTH'(dma_irq_fpga2host);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_h2f_q <= '0;
      cnt_f2h_q <= '0;
    end else begin
      cnt_h2f_q <= cnt_h2f_d;
      cnt_f2h_q <= cnt_f2h_d;
    end
  end

  assign cnt_h2f_rd = 64'(cnt_h2f_q);
  assign cnt_f2h_rd = 64'(cnt_f2h_q);
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
  assign cnt_h2f_rd       = '0;
  assign cnt_f2h_rd       = '0;
`endif

  // Read mux samples pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = '0;
    rvld_d  = avs.avs_read;
    if (avs.avs_read) begin
      case (avs.avs_address)
        3'd0:    rdata_d = {62'b0, status_q};
        3'd1:    rdata_d = {62'b0, enable_q};
        3'd2:    rdata_d = cnt_h2f_rd;
        3'd3:    rdata_d = cnt_f2h_rd;
        3'd4:    rdata_d = {63'b0, f2h_dma_wr_fence_flag};
        3'd5:    rdata_d = ID_VALUE;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvld_q;
  assign avs.avs_waitrequest   = 1'b0;

  assign pending = |(status_q & enable_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Once requested, the host must ack; a dropped enable never withdraws the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pending)  state_d = REQ;
      REQ:      if (irq_ack)  state_d = WAIT_CLR;
      WAIT_CLR: if (!pending) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_req = 1'b0;
    if (state_q == REQ) irq_req = 1'b1;
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{avs.avs_writedata[63:2], avs.avs_byteenable[7:1]};

endmodule
